// File: rtl/reg_block_arbiter.sv
// rtl/reg_block_arbiter.sv - round-robin arbiter sharing one register block write/read port pair
module reg_block_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int DATA_WIDTH        = 16,
    parameter int ADDR_WIDTH        = 9,
    parameter int WR_ADDR_WIDTH     = 7,
    parameter int ACTUAL_ADDR_WIDTH = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               ack,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             busy,
    output logic [DATA_WIDTH-1:0]            rb_data_in,
    output logic [WR_ADDR_WIDTH-1:0]         rb_addr_in,
    output logic [ADDR_WIDTH-1:0]            rb_addr_out,
    input  logic [DATA_WIDTH-1:0]            rb_data_out
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;

    state_t                   r_state, w_state_nxt;
    logic [IDX_W-1:0]         r_last, r_gnt, w_win;
    logic                     r_we, r_in_range, w_any;
    logic [ADDR_WIDTH-1:0]    w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic                     w_sel_we, w_sel_in_range;

    logic [NUM_REQ-1:0]       r_ack, w_ack_nxt;
    logic [DATA_WIDTH-1:0]    r_rdata, w_rdata_nxt;
    logic                     r_err, w_err_nxt, r_busy, w_busy_nxt;
    logic [DATA_WIDTH-1:0]    r_rb_data_in, w_rb_data_in_nxt;
    logic [WR_ADDR_WIDTH-1:0] r_rb_addr_in, w_rb_addr_in_nxt;
    logic [ADDR_WIDTH-1:0]    r_rb_addr_out, w_rb_addr_out_nxt;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_any = 1'b0;
        w_win = r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_any && req[idx]) begin
                w_any = 1'b1;
                w_win = IDX_W'(idx);
            end
        end
    end

    assign w_sel_addr     = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata    = req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel_we       = req_we[w_win];
    assign w_sel_in_range = (w_sel_addr[ADDR_WIDTH-1:ACTUAL_ADDR_WIDTH] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nxt = w_any ? S_ISSUE : S_IDLE;
            S_ISSUE: w_state_nxt = S_RESP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write address parks at all ones unless the next cycle is an in-range write ISSUE.
    always_comb begin
        w_ack_nxt         = '0;
        w_rdata_nxt       = r_rdata;
        w_err_nxt         = r_err;
        w_busy_nxt        = (w_state_nxt != S_IDLE);
        w_rb_addr_in_nxt  = '1;
        w_rb_data_in_nxt  = r_rb_data_in;
        w_rb_addr_out_nxt = r_rb_addr_out;
        case (r_state)
            S_IDLE: begin
                if (w_any && w_sel_in_range) begin
                    if (w_sel_we) begin
                        w_rb_addr_in_nxt = w_sel_addr[WR_ADDR_WIDTH-1:0];
                        w_rb_data_in_nxt = w_sel_wdata;
                    end else begin
                        w_rb_addr_out_nxt = w_sel_addr;
                    end
                end
            end
            S_ISSUE: begin
                w_ack_nxt[r_gnt] = 1'b1;
                w_err_nxt        = !r_in_range;
                w_rdata_nxt      = (r_in_range && !r_we) ? rb_data_out : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last        <= IDX_W'(NUM_REQ - 1);
            r_gnt         <= '0;
            r_we          <= 1'b0;
            r_in_range    <= 1'b0;
            r_ack         <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_rb_addr_in  <= '1;
            r_rb_data_in  <= '0;
            r_rb_addr_out <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_gnt      <= w_win;
                r_last     <= w_win;
                r_we       <= w_sel_we;
                r_in_range <= w_sel_in_range;
            end
            r_ack         <= w_ack_nxt;
            r_rdata       <= w_rdata_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= w_busy_nxt;
            r_rb_addr_in  <= w_rb_addr_in_nxt;
            r_rb_data_in  <= w_rb_data_in_nxt;
            r_rb_addr_out <= w_rb_addr_out_nxt;
        end
    end

    assign ack         = r_ack;
    assign rsp_rdata   = r_rdata;
    assign rsp_err     = r_err;
    assign busy        = r_busy;
    assign rb_addr_in  = r_rb_addr_in;
    assign rb_data_in  = r_rb_data_in;
    assign rb_addr_out = r_rb_addr_out;
endmodule

// File: tb/tb_reg_block_arbiter.sv
// tb/tb_reg_block_arbiter.sv - scoreboard bench for reg_block_arbiter with a register block stub
module tb_reg_block_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int AW  = 9;
    localparam int WAW = 7;

    typedef struct {
        int           id;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } op_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, busy;
    logic [DW-1:0]   rb_data_in;
    logic [WAW-1:0]  rb_addr_in;
    logic [AW-1:0]   rb_addr_out;
    logic [DW-1:0]   rb_data_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int park_viol = 0;
    int last_ack_cyc = -1;
    logic park_watch = 1'b0;
    logic rr_phase   = 1'b0;
    logic preload    = 1'b1;

    logic [DW-1:0] rb_mem [32];
    logic [DW-1:0] model  [32];
    exp_t exp_q [$];
    op_t  scr [N][$];

    reg_block_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WR_ADDR_WIDTH(WAW), .ACTUAL_ADDR_WIDTH(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .rb_data_in(rb_data_in), .rb_addr_in(rb_addr_in),
        .rb_addr_out(rb_addr_out), .rb_data_out(rb_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register block stub: writes every edge with an in-range address, combinational read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rb_mem[i] <= 16'h0100 + 16'(i);
        end else if (rb_addr_in[WAW-1:5] == '0) begin
            rb_mem[rb_addr_in[4:0]] <= rb_data_in;
        end
    end
    assign rb_data_out = (rb_addr_out[AW-1:5] == '0) ? rb_mem[rb_addr_out[4:0]] : '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (park_watch && rb_addr_in != '1) park_viol++;
        if (rst_n && ack != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(exp_q.size()), 1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_vec", 32'(ack), 32'(4'b0001 << e.id));
                check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
            end
            if (rr_phase && last_ack_cyc >= 0) check("ack_spacing", 32'(cyc - last_ack_cyc), 3);
            last_ack_cyc = cyc;
        end
    end

    task automatic push_exp(input int id, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd);
        exp_t e;
        e.id    = id;
        e.err   = (addr[AW-1:5] != '0);
        e.rdata = (!we && !e.err) ? model[addr[4:0]] : '0;
        if (we && !e.err) model[addr[4:0]] = wd;
        exp_q.push_back(e);
    endtask

    task automatic drive_fields(input int id, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wd);
        req_we[id]              = we;
        req_addr[id*AW +: AW]   = addr;
        req_wdata[id*DW +: DW]  = wd;
    endtask

    task automatic do_txn(input int id, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
        int c0;
        int n;
        @(negedge clk);
        push_exp(id, we, addr, wd);
        drive_fields(id, we, addr, wd);
        req[id] = 1'b1;
        c0 = cyc;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[id] && n < 20);
        check("ack_seen", 32'(ack[id]), 1);
        check("latency", 32'(cyc - c0), 2);
        req[id] = 1'b0;
        @(negedge clk);
    endtask

    task automatic add_op(input int id, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
        op_t o;
        o.we = we; o.addr = addr; o.wd = wd;
        scr[id].push_back(o);
    endtask

    task automatic run_batch();
        int n;
        op_t o;
        n = 0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (scr[i].size() > 0) begin
                o = scr[i].pop_front();
                drive_fields(i, o.we, o.addr, o.wd);
                req[i] = 1'b1;
            end
        end
        while (req != '0 && n < 200) begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if (scr[i].size() > 0) begin
                        o = scr[i].pop_front();
                        drive_fields(i, o.we, o.addr, o.wd);
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end
        check("batch_done", 32'(req), 0);
        req = '0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int diffs;
        rst_n = 1'b0;
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 32; i++) model[i] = 16'h0100 + 16'(i);
        @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(ack), 0);
        check("rst_rdata", 32'(rsp_rdata), 0);
        check("rst_err", 32'(rsp_err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr_in", 32'(rb_addr_in), 32'h7F);
        check("rst_data_in", 32'(rb_data_in), 0);
        check("rst_addr_out", 32'(rb_addr_out), 0);
        rst_n = 1'b1;

        do_txn(0, 1'b1, 9'd5, 16'hBEEF);
        do_txn(0, 1'b0, 9'd5, 16'h0000);

        park_watch = 1'b1;
        do_txn(1, 1'b1, 9'h040, 16'h1234);
        park_watch = 1'b0;
        check("park_oor_write", 32'(park_viol), 0);
        do_txn(0, 1'b0, 9'd0, 16'h0000);

        do_txn(2, 1'b0, 9'h1FF, 16'h0000);

        park_viol  = 0;
        park_watch = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_park", 32'(rb_addr_in), 32'h7F);
        end
        park_watch = 1'b0;
        diffs = 0;
        for (int i = 0; i < 32; i++) if (rb_mem[i] !== model[i]) diffs++;
        check("idle_mem_intact", 32'(diffs), 0);
        check("idle_park_viol", 32'(park_viol), 0);

        do_txn(3, 1'b0, 9'd3, 16'h0000);
        push_exp(0, 1'b1, 9'd10, 16'h1000);
        push_exp(1, 1'b1, 9'd11, 16'h1001);
        push_exp(2, 1'b1, 9'd12, 16'h1002);
        push_exp(3, 1'b1, 9'd13, 16'h1003);
        push_exp(0, 1'b0, 9'd13, 16'h0000);
        push_exp(1, 1'b0, 9'd10, 16'h0000);
        add_op(0, 1'b1, 9'd10, 16'h1000);
        add_op(1, 1'b1, 9'd11, 16'h1001);
        add_op(2, 1'b1, 9'd12, 16'h1002);
        add_op(3, 1'b1, 9'd13, 16'h1003);
        add_op(0, 1'b0, 9'd13, 16'h0000);
        add_op(1, 1'b0, 9'd10, 16'h0000);
        last_ack_cyc = -1;
        rr_phase = 1'b1;
        run_batch();
        rr_phase = 1'b0;

        @(negedge clk);
        drive_fields(0, 1'b1, 9'd7, 16'hAAAA);
        req[0] = 1'b1;
        @(posedge clk);
        #1;
        check("issue_addr_in", 32'(rb_addr_in), 32'd7);
        check("issue_busy", 32'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_addr_in", 32'(rb_addr_in), 32'h7F);
        check("rst_mid_ack", 32'(ack), 0);
        check("rst_mid_busy", 32'(busy), 0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_ack", 32'(ack), 0);
        rst_n = 1'b1;
        push_exp(0, 1'b0, 9'd7, 16'h0000);
        push_exp(2, 1'b0, 9'd7, 16'h0000);
        add_op(2, 1'b0, 9'd7, 16'h0000);
        add_op(0, 1'b0, 9'd7, 16'h0000);
        run_batch();

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
